// File: rtl/psg_envelope_gen.sv
// ---------------------------------------------------------------------------
// psg_envelope_gen
// ADSR envelope generator for a programmable sound generator voice.
//
// Ports
//   clk_i        : system clock, all state changes on the rising edge
//   rst_i        : synchronous active-high reset, wins over everything
//   ce           : clock enable; a rising edge with ce=1 is one "tick"
//   gate         : note on (1) / note off (0)
//   attack       : attack rate, one step every attack+1 ticks
//   decay        : decay rate, one step every decay+1 ticks
//   sustain      : sustain level 0..255
//   release_rate : release rate, one step every release_rate+1 ticks
//                  (named release_rate because "release" is a reserved word)
//   env          : registered envelope level
//   state_o      : IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   active       : 1 whenever state_o != IDLE
// ---------------------------------------------------------------------------
module psg_envelope_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce,
  input  logic       gate,
  input  logic [7:0] attack,
  input  logic [7:0] decay,
  input  logic [7:0] sustain,
  input  logic [7:0] release_rate,
  output logic [7:0] env,
  output logic [2:0] state_o,
  output logic       active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       gate_d;
  logic       rise;
  logic       fall;
  logic [7:0] rate;
  logic       fire;

  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;

  // Select the prescaler reload for the current ramping phase.
  always_comb begin
    rate = 8'd0;
    case (state)
      ATTACK:  rate = attack;
      DECAY:   rate = decay;
      RELEASE: rate = release_rate;
      default: rate = 8'd0;
    endcase
  end

  // A step fires on the tick where the prescaler has counted up to the rate.
  assign fire = (cnt == rate);

  // Envelope state machine, prescaler and gate edge register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      env    <= 8'd0;
      state  <= IDLE;
      cnt    <= 8'd0;
      gate_d <= 1'b0;
    end else if (ce) begin
      gate_d <= gate;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= ATTACK;
            cnt   <= 8'd0;
          end
        end
        ATTACK: begin
          if (fall) begin
            state <= RELEASE;
            cnt   <= 8'd0;
          end else if (env == 8'hFF) begin
            // Retriggered at full scale: move on without stepping.
            state <= DECAY;
            cnt   <= 8'd0;
          end else if (fire) begin
            cnt <= 8'd0;
            env <= env + 8'd1;
            if (env == 8'hFE) begin
              state <= DECAY;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DECAY: begin
          if (fall) begin
            state <= RELEASE;
            cnt   <= 8'd0;
          end else if (rise) begin
            state <= ATTACK;
            cnt   <= 8'd0;
          end else if (env <= sustain) begin
            // Sustain compare comes before stepping, so env never undershoots.
            state <= SUSTAIN;
            cnt   <= 8'd0;
          end else if (fire) begin
            cnt <= 8'd0;
            env <= env - 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SUSTAIN: begin
          if (fall) begin
            state <= RELEASE;
            cnt   <= 8'd0;
          end else if (rise) begin
            state <= ATTACK;
            cnt   <= 8'd0;
          end
        end
        RELEASE: begin
          if (rise) begin
            state <= ATTACK;
            cnt   <= 8'd0;
          end else if (env == 8'd0) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (fire) begin
            cnt <= 8'd0;
            env <= env - 8'd1;
            if (env == 8'd1) begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign state_o = state;
  assign active  = (state != IDLE);

endmodule

// File: doc/psg_envelope_gen.md
PSG_ENVELOPE_GEN -- requirements
Module: psg_envelope_gen

Interface
REQ-001 SHALL have ports, in order:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; a "tick" is a rising edge with ce=1.
- gate  in  1  note on (1) / note off (0).
- attack  in  8  attack rate; a step every attack+1 ticks.
- decay  in  8  decay rate; a step every decay+1 ticks.
- sustain  in  8  sustain level, 0..255.
- release  in  8  release rate; a step every release+1 ticks.
- env  out  8  envelope level, registered; feeds the shaper env input.
- state_o  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active  out  1  1 when state_o != IDLE.
REQ-002 SHALL have one clock domain (clk_i) and no parameters.

Function
REQ-003 SHALL register gate_d <= gate on each tick; rise = gate & ~gate_d; fall = ~gate & gate_d.
REQ-004 SHALL change no register (env, state, cnt, gate_d) on cycles where ce=0.
REQ-005 SHALL keep an 8-bit prescaler cnt; in ATTACK/DECAY/RELEASE on a tick:
- if cnt == active rate: cnt <= 0 and the step fires;
- else cnt <= cnt+1.
REQ-006 SHALL clear cnt to 0 on every state transition.
REQ-007 IDLE: env held; on rise -> ATTACK.
REQ-008 ATTACK, on a step: env <= env+1.
- If the new env = 255, same tick -> DECAY.
- If ATTACK is entered with env = 255: -> DECAY on the next tick, with no step.
REQ-009 DECAY, evaluated before stepping on each tick:
- if env <= sustain: -> SUSTAIN with env unchanged;
- else on a step: env <= env-1.
REQ-010 SUSTAIN: env held; later changes to the sustain input do not alter env.
REQ-011 RELEASE, on a step: env <= env-1.
- If the new env = 0, same tick -> IDLE.
- If RELEASE is entered with env = 0: -> IDLE on the next tick.
REQ-012 fall in ATTACK, DECAY or SUSTAIN SHALL -> RELEASE and override that tick's step; env is not changed that tick.
REQ-013 rise in DECAY, SUSTAIN or RELEASE SHALL -> ATTACK (retrigger) with env continuing from its current value, never reset to 0.
REQ-014 rise and fall cannot occur on the same tick; gate pulses shorter than one tick interval MAY be missed.
REQ-015 env arithmetic SHALL never wrap: no increment above 255, no decrement below 0.
REQ-016 Rate value 0 SHALL give one step per tick.
- Full attack 0->255 at rate r takes 255*(r+1) ticks.
REQ-017 env and state_o SHALL change on the tick edge itself (latency 0 from the tick); active is decoded combinationally from state.

Reset
REQ-018 With rst_i=1 at a rising edge, regardless of ce:
- env <= 0, state <= IDLE, cnt <= 0, gate_d <= 0;
- therefore active = 0.
REQ-019 Reset mid-envelope SHALL abort to IDLE with env=0 on that edge.
- A gate held high through reset release SHALL register as a rise on the first tick after reset and start ATTACK.
REQ-020 Reset SHALL take priority over all other behaviour.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- a) ce=1 every cycle, attack=0, decay=0, sustain=128, gate=1 -> env climbs 1/cycle to 255 over 255 ticks, state DECAY, decays to 128, then state SUSTAIN with env=128 held.
- b) attack=3, ce every 2nd cycle -> env increments once per 4 ticks (8 clocks); no change on ce=0 cycles.
- c) In SUSTAIN at env=128, gate->0, release=1 -> state RELEASE, env decrements every 2 ticks, reaches 0 after 256 ticks, then IDLE and active=0.
- d) Retrigger: in RELEASE at env=60, gate 0->1 -> ATTACK, env continues 61, 62, ...; sustain=255 -> DECAY then SUSTAIN on the next tick with env=255.
- e) rst_i=1 in ATTACK at env=100 with ce=0 -> next edge env=0, IDLE; gate still high -> ATTACK on the first tick after reset.
- f) Boundaries: rate 255 -> step every 256 ticks; sustain=0 -> decay to 0 then SUSTAIN with active=1; no wrap past 255 or below 0.
